// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side framer: FSM states,
// error codes, the default frame start byte and the checksum step.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    OUT     = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // One step of the running XOR checksum over the frame bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: DEPTH x 8 register file, one synchronous write
// port and one combinational read port. Contents are not reset; the framer
// only ever reads locations it has written for the current frame.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [DEPTH];

  // Store a payload byte when the framer pops one in the payload phase.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_framer.sv
// Packet framer behind the UART RX FIFO. Parses SYNC, LEN, PAYLOAD[LEN],
// CSUM, buffers the payload, verifies the XOR checksum and only then
// streams the payload out on a valid/ready byte port with end-of-frame.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC           = SYNC_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e             state_r;
  logic [7:0]         len_r;
  logic [7:0]         csum_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [TO_W-1:0]    to_cnt_r;

  logic               pop_s;
  logic               pop_state_s;
  logic               buf_we_s;
  logic [PTR_W-1:0]   rd_next_s;
  logic [PTR_W-1:0]   buf_raddr_s;
  logic [7:0]         buf_rdata_s;
  logic               to_expire_s;

  // The FIFO is only drained while parsing; in OUT backpressure stalls it.
  assign pop_state_s = (state_r == HUNT) || (state_r == LEN) ||
                       (state_r == PAYLOAD) || (state_r == CSUM);
  assign pop_s       = !reset && !rx_empty && pop_state_s;
  assign rd_uart     = pop_s;

  assign buf_we_s    = pop_s && (state_r == PAYLOAD);
  assign rd_next_s   = rd_ptr_r + PTR_W'(1);
  assign to_expire_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 2));

  // Read address: first byte is fetched while the checksum is checked,
  // later bytes are prefetched one ahead of the presented byte.
  always_comb begin
    buf_raddr_s = '0;
    if (state_r == OUT) begin
      buf_raddr_s = rd_next_s;
    end else begin
      buf_raddr_s = '0;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we_s),
    .waddr (wr_ptr_r),
    .wdata (r_data),
    .raddr (buf_raddr_s),
    .rdata (buf_rdata_s)
  );

  // Frame parser, inter-byte timeout and registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= HUNT;
      len_r     <= 8'd0;
      csum_r    <= 8'd0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      to_cnt_r  <= '0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        HUNT: begin
          to_cnt_r <= '0;
          if (pop_s && (r_data == SYNC)) begin
            state_r <= LEN;
          end else begin
            state_r <= HUNT;
          end
        end

        LEN, PAYLOAD, CSUM: begin
          if (pop_s) begin
            // A pop always wins over a coincident timeout expiry.
            to_cnt_r <= '0;
            case (state_r)
              LEN: begin
                if ((r_data == 8'd0) || (r_data > 8'(MAX_LEN))) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_LEN;
                  state_r   <= HUNT;
                end else begin
                  len_r    <= r_data;
                  csum_r   <= r_data;
                  wr_ptr_r <= '0;
                  state_r  <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                csum_r <= csum_step(csum_r, r_data);
                if (8'(wr_ptr_r) == (len_r - 8'd1)) begin
                  state_r <= CSUM;
                end else begin
                  wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
              end
              CSUM: begin
                if (r_data == csum_r) begin
                  frame_ok <= 1'b1;
                  rd_ptr_r <= '0;
                  m_valid  <= 1'b1;
                  m_data   <= buf_rdata_s;
                  m_last   <= (len_r == 8'd1);
                  state_r  <= OUT;
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CSUM;
                  state_r   <= HUNT;
                end
              end
              default: begin
                state_r <= HUNT;
              end
            endcase
          end else if (to_expire_s) begin
            to_cnt_r  <= '0;
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state_r   <= HUNT;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end

        OUT: begin
          to_cnt_r <= '0;
          if (m_valid && m_ready) begin
            if (m_last) begin
              m_valid  <= 1'b0;
              m_last   <= 1'b0;
              m_data   <= 8'd0;
              rd_ptr_r <= '0;
              state_r  <= HUNT;
            end else begin
              rd_ptr_r <= rd_next_s;
              m_data   <= buf_rdata_s;
              m_last   <= (8'(rd_next_s) == (len_r - 8'd1));
            end
          end
        end

        default: begin
          state_r <= HUNT;
        end
      endcase
    end
  end

endmodule
